// File: rtl/forth_loader.sv
// Boot loader: framed byte stream in, little-endian words out to imem.
// Holds the core in reset until a checksum-valid image has landed.
module forth_loader #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WIDTH-1:0]  imem_wd,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam int BYTES = (WIDTH + 7) / 8;
  localparam int BW    = BYTES * 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WC_W  = ADDR_W + 1;

  localparam logic [7:0]  MAGIC = 8'hA5;
  localparam logic [31:0] CAP   = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [15:0]     len;
  logic [7:0]      sum;
  logic [BC_W-1:0] byte_cnt;
  logic [WC_W-1:0] word_cnt;
  logic [BW-1:0]   word_buf;

  logic            take;
  logic            is_magic;
  logic [15:0]     n_in;
  logic [7:0]      sum_nx;
  logic            last_byte;
  logic            last_word;
  logic [BW-1:0]   asm_word;

  // Handshake and per-byte decode helpers
  always_comb begin
    rx_ready  = !reset && (state != S_DONE);
    take      = rx_valid && rx_ready;
    is_magic  = (rx_data == MAGIC);
    n_in      = {rx_data, len[7:0]};
    sum_nx    = sum + rx_data;
    last_byte = (byte_cnt == BC_W'(BYTES - 1));
    last_word = ({{(32-WC_W){1'b0}}, word_cnt} + 32'd1)
                == {16'd0, len};
  end

  // Merge the incoming byte into its lane of the word being assembled
  always_comb begin
    asm_word = word_buf;
    for (int i = 0; i < BYTES; i++) begin
      if (BC_W'(i) == byte_cnt) begin
        asm_word[8*i +: 8] = rx_data;
      end
    end
  end

  // Next-state decode; the FSM only moves on an accepted byte
  always_comb begin
    state_nx = state;
    if (take) begin
      unique case (state)
        S_IDLE: begin
          if (is_magic) state_nx = S_LEN_LO;
        end
        S_LEN_LO: begin
          state_nx = S_LEN_HI;
        end
        S_LEN_HI: begin
          if ({16'd0, n_in} > CAP) begin
            state_nx = S_ERR;
          end else if (n_in == 16'd0) begin
            state_nx = S_CSUM;
          end else begin
            state_nx = S_DATA;
          end
        end
        S_DATA: begin
          if (last_byte && last_word) begin
            state_nx = S_CSUM;
          end
        end
        S_CSUM: begin
          state_nx = (rx_data == sum) ? S_DONE : S_ERR;
        end
        S_DONE: begin
          state_nx = S_DONE;
        end
        S_ERR: begin
          if (is_magic) state_nx = S_LEN_LO;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Status outputs follow the state being entered so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      core_reset <= (state_nx != S_DONE);
      done       <= (state_nx == S_DONE);
      error      <= (state_nx == S_ERR);
    end
  end

  // Length capture, checksum, word assembly and imem writes
  always_ff @(posedge clk) begin
    if (reset) begin
      len       <= '0;
      sum       <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      word_buf  <= '0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (take) begin
        unique case (state)
          S_IDLE, S_ERR: begin
            if (is_magic) begin
              len      <= '0;
              sum      <= '0;
              byte_cnt <= '0;
              word_cnt <= '0;
              word_buf <= '0;
            end
          end
          S_LEN_LO: begin
            len[7:0] <= rx_data;
            sum      <= sum_nx;
          end
          S_LEN_HI: begin
            len[15:8] <= rx_data;
            sum       <= sum_nx;
          end
          S_DATA: begin
            sum      <= sum_nx;
            word_buf <= asm_word;
            if (last_byte) begin
              byte_cnt  <= '0;
              word_cnt  <= word_cnt + 1'b1;
              imem_we   <= 1'b1;
              imem_addr <= word_cnt[ADDR_W-1:0];
              imem_wd   <= asm_word[WIDTH-1:0];
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_forth_loader.sv
// Directed bench for forth_loader: frames, checksum, flow control,
// oversize length and mid-frame reset.
module tb_forth_loader;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WIDTH-1:0]  imem_wd;
  logic              core_reset;
  logic              done;
  logic              error;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [WIDTH-1:0]  wd[$];

  forth_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wd(imem_wd),
    .core_reset(core_reset),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write pulse seen between edges
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wd);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int k;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    chk("rst_ready", 32'(rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wd", 32'(imem_wd), 32'd0);
    chk("rst_core", 32'(core_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    wa.delete();
    wd.delete();
  endtask

  task automatic nominal(input int maxgap);
    logic [7:0] f [8];
    f = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
    for (int i = 0; i < 8; i++) begin
      send(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (i == 6) begin
        chk("nom_done_early", 32'(done), 32'd0);
        chk("nom_core_early", 32'(core_reset), 32'd1);
      end
    end
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_core", 32'(core_reset), 32'd0);
    chk("nom_ready", 32'(rx_ready), 32'd0);
    chk("nom_err", 32'(error), 32'd0);
    @(negedge clk);
    chk("nom_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("nom_a0", 32'(wa[0]), 32'd0);
      chk("nom_d0", 32'(wd[0]), 32'h1234);
      chk("nom_a1", 32'(wa[1]), 32'd1);
      chk("nom_d1", 32'(wd[1]), 32'h5678);
    end
    chk("nom_addr_hold", 32'(imem_addr), 32'd1);
    chk("nom_done_stick", 32'(done), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    do_reset();
    nominal(0);

    do_reset();
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hCD, 0);
    send(8'hAB, 0);
    send(8'h00, 0);
    chk("bad_err", 32'(error), 32'd1);
    chk("bad_core", 32'(core_reset), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("bad_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("bad_a0", 32'(wa[0]), 32'd0);
      chk("bad_d0", 32'(wd[0]), 32'hABCD);
    end
    send(8'hA5, 0);
    chk("retry_err_clr", 32'(error), 32'd0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hCD, 0);
    send(8'hAB, 0);
    send(8'h79, 0);
    chk("retry_done", 32'(done), 32'd1);
    chk("retry_core", 32'(core_reset), 32'd0);
    @(negedge clk);
    chk("retry_nwr", 32'(wa.size()), 32'd2);

    do_reset();
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_core", 32'(core_reset), 32'd0);
    @(negedge clk);
    chk("empty_nwr", 32'(wa.size()), 32'd0);

    do_reset();
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h01, 0);
    chk("big_err", 32'(error), 32'd1);
    send(8'h00, 0);
    send(8'h12, 1);
    send(8'h34, 0);
    chk("big_err_hold", 32'(error), 32'd1);
    chk("big_done", 32'(done), 32'd0);
    chk("big_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    chk("big_nwr", 32'(wa.size()), 32'd0);

    do_reset();
    send(8'h00, 0);
    send(8'hFF, 2);
    send(8'h5A, 1);
    chk("garb_err", 32'(error), 32'd0);
    nominal(3);

    do_reset();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h34, 0);
    do_reset();
    chk("mid_nwr", 32'(wa.size()), 32'd0);
    nominal(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
